// File: rtl/panxi_icache.sv
// Direct-mapped, read-only instruction cache. Misses refill a whole line, one word
// at a time, over a single-outstanding valid/ready memory bus; rw=1 invalidates all lines.
module panxi_icache #(
  parameter int PANXI_DW   = 32,
  parameter int AW         = 12,
  parameter int LINE_WORDS = 4,
  parameter int SETS       = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [AW-1:0]       icache_req_addr,
  input  logic                icache_req_vld,
  input  logic                icache_req_rw,
  output logic                icache_rdy,
  output logic                icache_hit,
  output logic [PANXI_DW-1:0] icache_data_rd,
  output logic                mem_req_vld,
  output logic [AW-1:0]       mem_req_addr,
  input  logic                mem_req_rdy,
  input  logic                mem_rsp_vld,
  input  logic [PANXI_DW-1:0] mem_rsp_data
);

  localparam int OW = $clog2(LINE_WORDS);
  localparam int IW = $clog2(SETS);
  localparam int TW = AW - 2 - OW - IW;

  localparam logic [2:0] IDLE        = 3'd0;
  localparam logic [2:0] LOOKUP      = 3'd1;
  localparam logic [2:0] REFILL_REQ  = 3'd2;
  localparam logic [2:0] REFILL_WAIT = 3'd3;
  localparam logic [2:0] RESP        = 3'd4;

  logic [2:0]          state;
  logic [AW-3:0]       word_addr;
  logic                rw_q;
  logic [SETS-1:0]     valid;
  logic [OW-1:0]       cnt;
  logic [OW-1:0]       next_cnt;
  logic [PANXI_DW-1:0] fill_word;
  logic [TW-1:0]       tag_arr  [SETS];
  logic [PANXI_DW-1:0] data_arr [SETS][LINE_WORDS];

  logic [OW-1:0] offset;
  logic [IW-1:0] index;
  logic [TW-1:0] tag;
  logic          lookup_hit;
  logic          unused_addr_lsbs;

  // Byte-offset bits never matter for a word fetch.
  assign unused_addr_lsbs = ^icache_req_addr[1:0];

  assign offset     = word_addr[OW-1:0];
  assign index      = word_addr[OW+IW-1:OW];
  assign tag        = word_addr[AW-3:OW+IW];
  assign lookup_hit = valid[index] && (tag_arr[index] == tag);
  assign next_cnt   = cnt + OW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      word_addr      <= '0;
      rw_q           <= 1'b0;
      valid          <= '0;
      cnt            <= '0;
      fill_word      <= '0;
      icache_rdy     <= 1'b0;
      icache_hit     <= 1'b0;
      icache_data_rd <= '0;
      mem_req_vld    <= 1'b0;
      mem_req_addr   <= '0;
    end else begin
      icache_rdy <= 1'b0;
      case (state)
        IDLE: begin
          if (icache_req_vld) begin
            word_addr <= icache_req_addr[AW-1:2];
            rw_q      <= icache_req_rw;
            state     <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (rw_q) begin
            valid      <= '0;
            icache_rdy <= 1'b1;
            icache_hit <= 1'b0;
            state      <= IDLE;
          end else if (lookup_hit) begin
            icache_rdy     <= 1'b1;
            icache_hit     <= 1'b1;
            icache_data_rd <= data_arr[index][offset];
            state          <= IDLE;
          end else begin
            // The line stays invalid until its last word lands, so an abort never exposes a partial line.
            valid[index] <= 1'b0;
            cnt          <= '0;
            mem_req_vld  <= 1'b1;
            mem_req_addr <= {word_addr[AW-3:OW], {OW{1'b0}}, 2'b00};
            state        <= REFILL_REQ;
          end
        end
        REFILL_REQ: begin
          if (mem_req_rdy) begin
            mem_req_vld <= 1'b0;
            state       <= REFILL_WAIT;
          end
        end
        REFILL_WAIT: begin
          if (mem_rsp_vld) begin
            if (cnt == offset) begin
              fill_word <= mem_rsp_data;
            end
            if (cnt == OW'(LINE_WORDS - 1)) begin
              valid[index] <= 1'b1;
              state        <= RESP;
            end else begin
              cnt          <= next_cnt;
              mem_req_vld  <= 1'b1;
              mem_req_addr <= {word_addr[AW-3:OW], next_cnt, 2'b00};
              state        <= REFILL_REQ;
            end
          end
        end
        RESP: begin
          icache_rdy     <= 1'b1;
          icache_hit     <= 1'b0;
          icache_data_rd <= fill_word;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Array contents need no reset; the valid bits alone decide what is usable.
  always_ff @(posedge clk) begin
    if (state == LOOKUP && !rw_q && !lookup_hit) begin
      tag_arr[index] <= tag;
    end
    if (state == REFILL_WAIT && mem_rsp_vld) begin
      data_arr[index][cnt] <= mem_rsp_data;
    end
  end

endmodule

// File: tb/tb_panxi_icache.sv
// Randomized self-checking bench for panxi_icache: a line-level cache model plus a
// memory responder with configurable backpressure and response delay.
module tb_panxi_icache;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] req_addr = '0;
  logic        req_vld = 1'b0;
  logic        req_rw = 1'b0;
  logic        icache_rdy;
  logic        icache_hit;
  logic [31:0] icache_data_rd;
  logic        mem_req_vld;
  logic [11:0] mem_req_addr;
  logic        mem_req_rdy = 1'b0;
  logic        mem_rsp_vld = 1'b0;
  logic [31:0] mem_rsp_data = '0;

  int n_checks = 0;
  int n_fail = 0;

  logic [31:0] mem [1024];
  bit          m_valid [16];
  logic [7:0]  m_line [16];
  logic [31:0] last_data = '0;

  bit          exp_pending = 1'b0;
  bit          exp_hit = 1'b0;
  logic [31:0] exp_data = '0;
  bit          got_rdy = 1'b0;
  bit          cap_hit = 1'b0;
  logic [31:0] cap_data = '0;
  logic [31:0] held_data = '0;
  logic [11:0] exp_mem_q [$];
  logic [11:0] req_log [$];

  bit          seen_vld = 1'b0;
  logic [11:0] seen_addr = '0;
  bit          outstanding = 1'b0;
  logic [11:0] out_addr = '0;
  int          rsp_wait = 0;
  int          bp_wait = 0;
  int          bp_cycles = 0;
  int          rsp_delay = 0;
  bit          rand_mem = 1'b0;
  int          rsp_count = 0;
  bit          stray = 1'b0;

  panxi_icache dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .icache_req_addr(req_addr),
    .icache_req_vld (req_vld),
    .icache_req_rw  (req_rw),
    .icache_rdy     (icache_rdy),
    .icache_hit     (icache_hit),
    .icache_data_rd (icache_data_rd),
    .mem_req_vld    (mem_req_vld),
    .mem_req_addr   (mem_req_addr),
    .mem_req_rdy    (mem_req_rdy),
    .mem_rsp_vld    (mem_rsp_vld),
    .mem_rsp_data   (mem_rsp_data)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory responder: one request in flight, words served from the mem array.
  always @(negedge clk) begin
    bit accepted;
    if (!rst_n) begin
      mem_req_rdy = 1'b0;
      mem_rsp_vld = 1'b0;
      outstanding = 1'b0;
      seen_vld    = 1'b0;
      bp_wait     = 0;
    end else begin
      accepted    = seen_vld && mem_req_rdy;
      mem_rsp_vld = 1'b0;
      if (accepted) begin
        checkOutput("single_outstanding", 32'(outstanding), 0);
        outstanding = 1'b1;
        out_addr    = seen_addr;
        rsp_wait    = rand_mem ? int'($urandom_range(0, 2)) : rsp_delay;
      end
      if (seen_vld && !accepted) begin
        checkOutput("mem_req_vld_stable", 32'(mem_req_vld), 1);
        checkOutput("mem_req_addr_stable", 32'(mem_req_addr), 32'(seen_addr));
      end else if (mem_req_vld) begin
        req_log.push_back(mem_req_addr);
        checkOutput("no_req_while_outstanding", 32'(outstanding), 0);
        if (exp_mem_q.size() == 0) checkOutput("unexpected_mem_req", 32'(mem_req_addr), 32'hFFFF_FFFF);
        else checkOutput("mem_req_addr", 32'(mem_req_addr), 32'(exp_mem_q.pop_front()));
        bp_wait = rand_mem ? int'($urandom_range(0, 2)) : bp_cycles;
      end
      if (outstanding) begin
        if (rsp_wait == 0) begin
          mem_rsp_vld  = 1'b1;
          mem_rsp_data = mem[out_addr[11:2]];
          outstanding  = 1'b0;
          rsp_count++;
        end else begin
          rsp_wait--;
        end
      end else if (stray) begin
        mem_rsp_vld  = 1'b1;
        mem_rsp_data = 32'hDEAD_BEEF;
        stray        = 1'b0;
      end
      mem_req_rdy = 1'b0;
      if (mem_req_vld) begin
        if (bp_wait > 0) bp_wait--;
        else mem_req_rdy = 1'b1;
      end
      seen_vld  = mem_req_vld;
      seen_addr = mem_req_addr;
    end
  end

  // Response checker: every rdy must match a pending prediction; data holds in between.
  always @(negedge clk) begin
    if (!rst_n) begin
      held_data = '0;
    end else if (icache_rdy) begin
      if (!exp_pending) begin
        checkOutput("rdy_without_request", 32'(icache_rdy), 0);
      end else begin
        checkOutput("hit", 32'(icache_hit), 32'(exp_hit));
        checkOutput("data", icache_data_rd, exp_data);
        cap_hit     = icache_hit;
        cap_data    = icache_data_rd;
        held_data   = exp_data;
        exp_pending = 1'b0;
        got_rdy     = 1'b1;
      end
    end else begin
      checkOutput("data_held", icache_data_rd, held_data);
    end
  end

  task automatic predict(input logic [11:0] a, input bit rw, output bit is_hit);
    logic [3:0] set_i;
    logic [7:0] line;
    set_i  = a[7:4];
    line   = a[11:4];
    is_hit = 1'b0;
    if (rw) begin
      for (int s = 0; s < 16; s++) m_valid[s] = 1'b0;
      exp_data = last_data;
    end else begin
      is_hit   = m_valid[set_i] && (m_line[set_i] == line);
      exp_data = mem[a[11:2]];
      if (!is_hit) begin
        for (int w = 0; w < 4; w++) exp_mem_q.push_back({line, 4'h0} + 12'(4 * w));
        m_valid[set_i] = 1'b1;
        m_line[set_i]  = line;
      end
    end
    exp_hit   = is_hit;
    last_data = exp_data;
  endtask

  task automatic applyStimulus(input logic [11:0] a, input bit rw);
    bit is_hit;
    int lat;
    @(negedge clk); #1;
    predict(a, rw, is_hit);
    got_rdy     = 1'b0;
    exp_pending = 1'b1;
    req_addr    = a;
    req_rw      = rw;
    req_vld     = 1'b1;
    lat         = 0;
    while (!got_rdy && lat < 300) begin
      @(negedge clk); #1;
      lat++;
    end
    req_vld = 1'b0;
    if (!got_rdy) begin
      checkOutput("rdy_timeout", 0, 1);
      exp_pending = 1'b0;
    end
    if (rw || is_hit) checkOutput("short_latency", 32'(lat), 2);
    checkOutput("refill_words_issued", 32'(exp_mem_q.size()), 0);
  endtask

  task automatic checkLog(input string name, input logic [11:0] base);
    checkOutput({name, "_count"}, 32'(req_log.size()), 4);
    for (int i = 0; i < 4 && i < req_log.size(); i++)
      checkOutput(name, 32'(req_log[i]), 32'(base + 12'(4 * i)));
  endtask

  initial begin
    int base;
    int guard;
    int idx_tbl [4];
    logic [11:0] a;
    idx_tbl = '{0, 3, 5, 9};
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    for (int i = 0; i < 4; i++) mem[32'h40 + i] = 32'hA0 + 32'(i);
    for (int s = 0; s < 16; s++) m_valid[s] = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("reset_rdy", 32'(icache_rdy), 0);
    checkOutput("reset_hit", 32'(icache_hit), 0);
    checkOutput("reset_data", icache_data_rd, 0);
    checkOutput("reset_mem_req_vld", 32'(mem_req_vld), 0);
    checkOutput("reset_mem_req_addr", 32'(mem_req_addr), 0);
    #1 rst_n = 1'b1;

    $display("[TB] cold miss and warm hit");
    req_log.delete();
    applyStimulus(12'h104, 1'b0);
    checkOutput("cold_miss_hit", 32'(cap_hit), 0);
    checkOutput("cold_miss_data", cap_data, 32'hA1);
    checkLog("cold_miss_addr", 12'h100);
    applyStimulus(12'h10C, 1'b0);
    checkOutput("warm_hit_hit", 32'(cap_hit), 1);
    checkOutput("warm_hit_data", cap_data, 32'hA3);

    $display("[TB] conflict eviction");
    req_log.delete();
    applyStimulus(12'h200, 1'b0);
    checkLog("conflict_addr", 12'h200);
    applyStimulus(12'h100, 1'b0);
    checkOutput("conflict_refetch_hit", 32'(cap_hit), 0);
    checkOutput("conflict_refetch_data", cap_data, 32'hA0);

    $display("[TB] invalidate all");
    applyStimulus(12'h130, 1'b0);
    applyStimulus(12'h100, 1'b0);
    checkOutput("pre_inval_hit", 32'(cap_hit), 1);
    applyStimulus(12'h000, 1'b1);
    checkOutput("inval_hit", 32'(cap_hit), 0);
    applyStimulus(12'h100, 1'b0);
    checkOutput("post_inval_100_hit", 32'(cap_hit), 0);
    applyStimulus(12'h130, 1'b0);
    checkOutput("post_inval_130_hit", 32'(cap_hit), 0);

    $display("[TB] memory backpressure");
    bp_cycles = 5;
    rsp_delay = 3;
    applyStimulus(12'h2F8, 1'b0);
    bp_cycles = 0;
    rsp_delay = 0;

    $display("[TB] reset mid-refill");
    base = rsp_count;
    @(negedge clk); #1;
    for (int w = 0; w < 4; w++) exp_mem_q.push_back(12'h350 + 12'(4 * w));
    req_addr = 12'h35C;
    req_rw   = 1'b0;
    req_vld  = 1'b1;
    guard    = 0;
    while (rsp_count < base + 2 && guard < 200) begin
      @(negedge clk); #1;
      guard++;
    end
    if (guard >= 200) checkOutput("mid_refill_timeout", 0, 1);
    @(negedge clk); #1;
    rst_n   = 1'b0;
    req_vld = 1'b0;
    exp_mem_q.delete();
    for (int s = 0; s < 16; s++) m_valid[s] = 1'b0;
    last_data = '0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    stray = 1'b1;
    repeat (3) @(negedge clk);
    req_log.delete();
    applyStimulus(12'h35C, 1'b0);
    checkOutput("post_reset_hit", 32'(cap_hit), 0);
    checkLog("post_reset_addr", 12'h350);

    $display("[TB] randomized traffic");
    rand_mem = 1'b1;
    for (int n = 0; n < 200; n++) begin
      a = {4'($urandom_range(0, 3)), 4'(idx_tbl[$urandom_range(0, 3)]), 4'($urandom_range(0, 15))};
      applyStimulus(a, $urandom_range(0, 19) == 0);
    end
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
